// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH unsigned shift-and-add multiplier.
// Each iteration goes through the shared external 32-bit ripple adder
// (fulladderN). The adder is driven on add_a/add_b, and its sum and carry-out
// come back on add_sum/add_cout in the same cycle. One iteration runs per
// clock, and there are 32 iterations per multiply.
//
// Optional feature macro: SIGNED_MULT_EN
//   When defined, is_signed=1 multiplies two's-complement operands. The
//   operand magnitudes go through the datapath, and an extra NEG cycle negates
//   the 64-bit result when the signs differ. When undefined, is_signed is
//   ignored and every multiply is unsigned.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      request a multiply (sampled only in IDLE)
//   is_signed  operands are two's complement (SIGNED_MULT_EN only)
//   op_a       multiplicand
//   op_b       multiplier
//   add_a      to shared adder input a
//   add_b      to shared adder input b
//   add_sum    from shared adder sum
//   add_cout   from shared adder carry-out
//   busy       high while a multiply is in progress (RUN/NEG)
//   done       one-cycle pulse once product holds the new result
//   product    result, held until the next accepted start or rst
//
// Timing: start sampled at edge N, RUN during the 32 cycles after edges
// N..N+31, DONE after edge N+32, and done high in the cycle after edge N+33.
// The product register is loaded on entry to DONE, so it is already stable
// when done is seen. A negated signed result adds one NEG cycle.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 32,  // only 32 is supported (adder width is fixed)
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef SIGNED_MULT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_NEG  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  // One shift-add step. The adder result is 33 bits ({cout, sum}). Appending
  // the low half and dropping bit 0 gives the 65-bit value shifted right by
  // one, so the carry lands in bit 63 and nothing can overflow.
  logic [2*WIDTH-1:0]   p_step;

`ifdef SIGNED_MULT_EN
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // Two's-complement magnitudes. 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude 2^31.
  always_comb begin
    mag_a = op_a;
    mag_b = op_b;
    if (is_signed) begin
      if (op_a[WIDTH-1]) begin
        mag_a = ~op_a + {{(WIDTH-1){1'b0}}, 1'b1};
      end
      if (op_b[WIDTH-1]) begin
        mag_b = ~op_b + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  logic                 is_signed_unused;
  assign is_signed_unused = is_signed;
`endif

  assign p_step = {add_cout, add_sum, p_q[WIDTH-1:1]};

  // Next-state, datapath and adder-drive logic. Outside RUN the adder inputs
  // are held at zero so the shared adder sees a quiet bus.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    add_a     = '0;
    add_b     = '0;
    busy      = 1'b0;
`ifdef SIGNED_MULT_EN
    neg_d     = neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SIGNED_MULT_EN
          m_d   = mag_a;
          p_d   = {{WIDTH{1'b0}}, mag_b};
          neg_d = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
          m_d   = op_a;
          p_d   = {{WIDTH{1'b0}}, op_b};
`endif
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy  = 1'b1;
        add_a = p_q[2*WIDTH-1:WIDTH];
        add_b = p_q[0] ? m_q : '0;
        p_d   = p_step;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_ITER) begin
`ifdef SIGNED_MULT_EN
          if (neg_q) begin
            state_d = S_NEG;
          end else begin
            state_d   = S_DONE;
            product_d = p_step;
          end
`else
          state_d   = S_DONE;
          product_d = p_step;
`endif
        end
      end

`ifdef SIGNED_MULT_EN
      // The 64-bit negation is done locally because the shared adder is
      // only 32 bits wide.
      S_NEG: begin
        busy      = 1'b1;
        p_d       = ~p_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
        product_d = p_d;
        state_d   = S_DONE;
      end
`endif

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, including a start in the
  // same cycle, and discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef SIGNED_MULT_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef SIGNED_MULT_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Bench for shift_add_multiplier. A behavioural 32-bit adder stands in for
// fulladderN. Every accepted start pushes the expected product, the done
// cycle and the busy length onto a scoreboard. A negedge monitor pops one
// entry on each done pulse and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [63:0] product;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
    int          busy_len;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          done_count = 0;
  logic        prev_done = 1'b0;
  logic        cout_seen = 1'b0;
  logic [63:0] last_exp = '0;
  int          dc;

  shift_add_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Model of the shared ripple adder: purely combinational, no carry-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges so latency can be checked in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference product and timing for one operation.
  function automatic exp_t modelOp(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int start_edge);
    exp_t e;
    logic signed [63:0] sa;
    logic signed [63:0] sb_v;
    int extra;
    extra = 0;
`ifdef SIGNED_MULT_EN
    if (s) begin
      sa   = $signed({{32{a[31]}}, a});
      sb_v = $signed({{32{b[31]}}, b});
      e.prod = sa * sb_v;
      if (a[31] ^ b[31]) extra = 1;
    end else begin
      e.prod = {32'h0, a} * {32'h0, b};
    end
`else
    sa   = '0;
    sb_v = '0;
    if (s) extra = 0;
    e.prod = {32'h0, a} * {32'h0, b};
`endif
    e.cyc      = start_edge + 33 + extra;
    e.busy_len = 32 + extra;
    return e;
  endfunction

  // Drives one start pulse and records the expected outcome. Returns #1
  // after the sampling edge with the operands scrambled, so later op_a/op_b
  // changes are exercised on every operation.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s);
    exp_t e;
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    is_signed = s;
    start     = 1'b1;
    e = modelOp(a, b, s, cyc + 1);
    sb.push_back(e);
    last_exp = e.prod;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy && add_cout) cout_seen = 1'b1;
    if (done) begin
      done_count++;
      checkOutput("done_single", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("product", product, e.prod);
        checkOutput("latency", 64'(cyc), 64'(e.cyc));
        checkOutput("busy_len", 64'(busy_cnt), 64'(e.busy_len));
      end
      busy_cnt = 0;
    end
    prev_done = done;
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_product", product, 64'd0);
    checkOutput("rst_add_a", 64'(add_a), 64'd0);
    checkOutput("rst_add_b", 64'(add_b), 64'd0);
    rst = 1'b0;
    busy_cnt = 0;

    // 3*5, with a look at the first iteration's adder drive
    applyStimulus(32'd3, 32'd5, 1'b0);
    checkOutput("run_busy", 64'(busy), 64'd1);
    checkOutput("run_add_a", 64'(add_a), 64'd0);
    checkOutput("run_add_b", 64'(add_b), 64'd3);
    checkOutput("run_product_held", product, 64'd0);
    waitDone(60);
    repeat (3) @(negedge clk);
    checkOutput("product_hold", product, 64'h0000_0000_0000_000F);

    // Max operands: the carry-out must reach bit 63
    cout_seen = 1'b0;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("prev_product_held", product, 64'h0000_0000_0000_000F);
    waitDone(60);
    checkOutput("cout_seen", 64'(cout_seen), 64'd1);
    checkOutput("max_product", product, 64'hFFFF_FFFE_0000_0001);

    // A start while busy is ignored
    dc = done_count;
    applyStimulus(32'd7, 32'd9, 1'b0);
    repeat (5) @(negedge clk);
    op_a  = 32'd2;
    op_b  = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(60);
    repeat (40) @(negedge clk);
    checkOutput("ignored_start_dones", 64'(done_count - dc), 64'd1);
    checkOutput("ignored_start_product", product, 64'h3F);

    // Reset mid-run, with a start in the same reset cycle
    dc = done_count;
    applyStimulus(32'd3, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'd9;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    sb.delete();
    busy_cnt = 0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_product", product, 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 64'(done_count - dc), 64'd0);
    checkOutput("abort_idle", 64'(busy), 64'd0);
    applyStimulus(32'd4, 32'd6, 1'b0);
    waitDone(60);
    checkOutput("after_abort_product", product, 64'h18);

    // Back-to-back operations, including boundary operands
    begin
      logic [31:0] va[6];
      logic [31:0] vb[6];
      va[0] = 32'h0;         vb[0] = 32'hFFFF_FFFF;
      va[1] = 32'h8000_0000; vb[1] = 32'h2;
      va[2] = 32'h1;         vb[2] = 32'h1;
      va[3] = 32'hFFFF_FFFF; vb[3] = 32'h1;
      va[4] = $urandom;      vb[4] = $urandom;
      va[5] = $urandom;      vb[5] = $urandom;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(va[i], vb[i], 1'b0);
        waitDone(60);
        checkOutput("b2b_product", product, last_exp);
      end
    end

`ifdef SIGNED_MULT_EN
    applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b1);
    waitDone(60);
    checkOutput("signed_neg", product, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
    waitDone(60);
    checkOutput("signed_min_sq", product, 64'h4000_0000_0000_0000);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitDone(60);
    checkOutput("signed_m1_sq", product, 64'h1);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
    waitDone(60);
    checkOutput("signed_7xm2", product, 64'hFFFF_FFFF_FFFF_FFF2);
`else
    applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b1);
    waitDone(60);
    checkOutput("is_signed_ignored", product, 64'h0000_0004_FFFF_FFF1);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
